// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (state encoding and line levels) used by
// the transmitter and by the future receiver block.
package uart_pkg;

  // Frame sequencing states; PARITY is only reached when UART_TX_PARITY_EN is set.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Serial line levels.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer. Counts 0..CLKS_PER_BIT-1 and raises tick
// on the terminal count. 'clear' restarts the period so every bit lasts exactly
// CLKS_PER_BIT cycles after a state change. Shared with the receiver.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Free-running period counter that wraps on terminal count or restarts on clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST_COUNT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST_COUNT);

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. Accepts one word through a valid/ready
// handshake while idle and sends it LSB-first as start bit, data bits,
// optional even-parity bit and stop bit on an idle-high registered line.
// Optional feature: define UART_TX_PARITY_EN to insert the parity bit.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  import uart_pkg::*;

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_state_t          state;
  uart_state_t          state_next;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_next;
  logic [BW-1:0]        bit_cnt;
  logic [BW-1:0]        bit_cnt_next;
  logic                 tx_q;
  logic                 tx_next;
  logic                 done_q;
  logic                 accept;
  logic                 baud_clear;
  logic                 baud_tick;

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  // Even parity of the word, captured at accept so later tx_data changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^tx_data;
    end
  end
`endif

  assign tx_ready = (state == IDLE);
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state != IDLE);
  assign tx       = tx_q;
  assign done     = done_q;

  // The bit period restarts on every state change and is held at zero while idle.
  assign baud_clear = (state == IDLE) || (state_next != state);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  // Next-state, shift-register and bit-index logic for the frame sequencer.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next   = START;
          shreg_next   = tx_data;
          bit_cnt_next = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shreg_next = shreg >> 1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, derived from where the sequencer is heading.
  always_comb begin
    tx_next = LINE_IDLE;
    case (state_next)
      START:   tx_next = START_BIT;
      DATA:    tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_q;
`endif
      STOP:    tx_next = STOP_BIT;
      default: tx_next = LINE_IDLE;
    endcase
  end

  // State, data and registered line output; done pulses on the first idle cycle after stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      tx_q    <= LINE_IDLE;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_cnt <= bit_cnt_next;
      tx_q    <= tx_next;
      done_q  <= (state == STOP) && baud_tick;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: self-checking bench for uart_tx_frame (CLKS_PER_BIT=4,
// DATA_BITS=8). Expected line waveforms come from a frame model built from the
// UART framing rules. Honours UART_TX_PARITY_EN when defined.
module tb_uart_tx_frame;

  localparam int CLKS = 4;
  localparam int DB   = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_CYC = CLKS;
`else
  localparam int PAR_CYC = 0;
`endif
  localparam int FRAME_LEN = (DB + 2) * CLKS + PAR_CYC;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_valid;
  logic [DB-1:0] tx_data;
  logic          tx_ready;
  logic          tx;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];
  bit first_q[$];

  always #5 clk = ~clk;

  uart_tx_frame #(
    .CLKS_PER_BIT (CLKS),
    .DATA_BITS    (DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  // Advance one cycle and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame model: per-cycle line level for one word, starting with the first start-bit cycle.
  task automatic model_frame(input logic [DB-1:0] w);
    exp_q.delete();
    for (int i = 0; i < CLKS; i++) exp_q.push_back(1'b0);
    for (int b = 0; b < DB; b++)
      for (int i = 0; i < CLKS; i++) exp_q.push_back(w[b]);
`ifdef UART_TX_PARITY_EN
    for (int i = 0; i < CLKS; i++) exp_q.push_back(^w);
`endif
    for (int i = 0; i < CLKS; i++) exp_q.push_back(1'b1);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({tx, tx_ready, busy, done} !== 4'b1100) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d: {tx,ready,busy,done} got %b expected 1100", c, {tx, tx_ready, busy, done});
      end
    end
    rst      = 1'b0;
    tx_valid = 1'b0;
    step();
    checks++;
    if ({tx, tx_ready, busy, done} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL reset_release: {tx,ready,busy,done} got %b expected 1100", {tx, tx_ready, busy, done});
    end
  endtask

  task automatic test_single_frame(input logic [DB-1:0] w);
    model_frame(w);
    tx_valid = 1'b1;
    tx_data  = w;
    step();
    tx_valid = 1'b0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      tx_data = DB'($urandom);
      checks++;
      if ({tx, tx_ready, busy, done} !== {exp_q[k], 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL frame_%h cycle %0d: {tx,ready,busy,done} got %b expected %b", w, k + 1, {tx, tx_ready, busy, done}, {exp_q[k], 3'b010});
      end
      step();
    end
    checks++;
    if ({tx, tx_ready, busy, done} !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL frame_%h done cycle: {tx,ready,busy,done} got %b expected 1101", w, {tx, tx_ready, busy, done});
    end
    step();
    checks++;
    if ({tx, tx_ready, busy, done} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL frame_%h after done: {tx,ready,busy,done} got %b expected 1100", w, {tx, tx_ready, busy, done});
    end
  endtask

  task automatic test_back_to_back(input logic [DB-1:0] a, input logic [DB-1:0] b);
    model_frame(a);
    first_q = exp_q;
    model_frame(b);
    tx_valid = 1'b1;
    tx_data  = a;
    step();
    tx_data = b;
    for (int k = 0; k < FRAME_LEN; k++) begin
      checks++;
      if ({tx, tx_ready, busy, done} !== {first_q[k], 3'b010}) begin
        errors++;
        $display("[TB] FAIL b2b_first cycle %0d: {tx,ready,busy,done} got %b expected %b", k + 1, {tx, tx_ready, busy, done}, {first_q[k], 3'b010});
      end
      step();
    end
    checks++;
    if ({tx, tx_ready, busy, done} !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL b2b_done_accept: {tx,ready,busy,done} got %b expected 1101", {tx, tx_ready, busy, done});
    end
    step();
    tx_valid = 1'b0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      checks++;
      if ({tx, tx_ready, busy, done} !== {exp_q[k], 3'b010}) begin
        errors++;
        $display("[TB] FAIL b2b_second cycle %0d: {tx,ready,busy,done} got %b expected %b", FRAME_LEN + 2 + k, {tx, tx_ready, busy, done}, {exp_q[k], 3'b010});
      end
      step();
    end
    checks++;
    if ({tx, tx_ready, busy, done} !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL b2b_second_done: {tx,ready,busy,done} got %b expected 1101", {tx, tx_ready, busy, done});
    end
    step();
  endtask

  task automatic test_busy_reject();
    model_frame(8'h3C);
    first_q = exp_q;
    model_frame(8'hFF);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    step();
    tx_valid = 1'b0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      if (k + 1 == 10) begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
      end
      checks++;
      if ({tx, tx_ready, busy, done} !== {first_q[k], 3'b010}) begin
        errors++;
        $display("[TB] FAIL busy_reject_3c cycle %0d: {tx,ready,busy,done} got %b expected %b", k + 1, {tx, tx_ready, busy, done}, {first_q[k], 3'b010});
      end
      step();
    end
    checks++;
    if ({tx, tx_ready, busy, done} !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL busy_reject_done: {tx,ready,busy,done} got %b expected 1101", {tx, tx_ready, busy, done});
    end
    step();
    tx_valid = 1'b0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      checks++;
      if ({tx, tx_ready, busy, done} !== {exp_q[k], 3'b010}) begin
        errors++;
        $display("[TB] FAIL busy_reject_ff cycle %0d: {tx,ready,busy,done} got %b expected %b", k + 1, {tx, tx_ready, busy, done}, {exp_q[k], 3'b010});
      end
      step();
    end
    checks++;
    if ({tx, tx_ready, busy, done} !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL busy_reject_ff_done: {tx,ready,busy,done} got %b expected 1101", {tx, tx_ready, busy, done});
    end
    step();
  endtask

  task automatic test_reset_mid();
    model_frame(8'hC3);
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    step();
    tx_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      checks++;
      if ({tx, tx_ready, busy, done} !== {exp_q[k], 3'b010}) begin
        errors++;
        $display("[TB] FAIL reset_mid_c3 cycle %0d: {tx,ready,busy,done} got %b expected %b", k + 1, {tx, tx_ready, busy, done}, {exp_q[k], 3'b010});
      end
      if (k < 17) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({tx, tx_ready, busy, done} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL reset_mid_abort: {tx,ready,busy,done} got %b expected 1100", {tx, tx_ready, busy, done});
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({tx, tx_ready, busy, done} !== 4'b1100) begin
        errors++;
        $display("[TB] FAIL reset_mid_quiet cycle %0d: {tx,ready,busy,done} got %b expected 1100", c, {tx, tx_ready, busy, done});
      end
    end
    test_single_frame(8'h81);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [DB-1:0] words [2];
    logic          par_exp [2];
    words[0] = 8'h07; par_exp[0] = 1'b1;
    words[1] = 8'h03; par_exp[1] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      tx_valid = 1'b1;
      tx_data  = words[n];
      step();
      tx_valid = 1'b0;
      for (int c = 1; c <= 44; c++) begin
        if (c >= 37 && c <= 40) begin
          checks++;
          if (tx !== par_exp[n]) begin
            errors++;
            $display("[TB] FAIL parity_%h cycle %0d: tx got %b expected %b", words[n], c, tx, par_exp[n]);
          end
        end else if (c >= 41) begin
          checks++;
          if ({tx, done} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL parity_stop_%h cycle %0d: {tx,done} got %b expected 10", words[n], c, {tx, done});
          end
        end
        step();
      end
      checks++;
      if ({tx, tx_ready, busy, done} !== 4'b1101) begin
        errors++;
        $display("[TB] FAIL parity_done_%h cycle 45: {tx,ready,busy,done} got %b expected 1101", words[n], {tx, tx_ready, busy, done});
      end
      step();
    end
  endtask
`endif

  task automatic test_random();
    logic [DB-1:0] w;
    logic [DB-1:0] w2;
    int            gap;
    for (int n = 0; n < 6; n++) begin
      w   = DB'($urandom);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step();
      test_single_frame(w);
    end
    for (int n = 0; n < 2; n++) begin
      w  = DB'($urandom);
      w2 = DB'($urandom);
      test_back_to_back(w, w2);
    end
  endtask

  // Bound on total run time so a stuck design still ends the run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence.
  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    test_reset();
    test_single_frame(8'h55);
    test_back_to_back(8'hA5, 8'h0F);
    test_busy_reject();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter: the sending end of the serial link whose receive side feeds the pattern detector.
- Accepts one parallel word through a valid/ready handshake and serializes it LSB-first as start bit, data bits, and stop bit on a single idle-high line.
- Used as the stimulus source for the detector path and as the board-level TX.

Parameters:
- CLKS_PER_BIT, default 16: clock cycles per bit period; minimum 2.
- DATA_BITS, default 8: payload width; range 5..8.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- tx_data  in  DATA_BITS  word to send; sampled only on the accept cycle.
- tx_valid  in  1  source has a word.
- tx_ready  out  1  block can accept a word this cycle.
- tx  out  1  serial line, registered, idle high.
- busy  out  1  high while a frame is in flight.
- done  out  1  single-cycle pulse after the stop bit completes.

Behaviour:
- Reset values: tx=1, tx_ready=1, busy=0, done=0, state=IDLE, bit counter=0, baud counter=0.
- Reset is synchronous: rst is sampled on the clk edge like any other input.
- Accept: a word is accepted on an edge where tx_valid & tx_ready. tx_data is latched into a shift register.
- tx_ready=1 only in IDLE; it is 0 in every other state.
- tx_valid while busy is ignored. Nothing is queued.
- State machine:
  - IDLE -> START on accept.
  - START (tx=0, CLKS_PER_BIT cycles) -> DATA.
  - DATA (tx=shreg[0], each bit CLKS_PER_BIT cycles, shift right after each bit, DATA_BITS bits) -> PARITY if enabled, else STOP.
  - PARITY -> STOP.
  - STOP (tx=1, CLKS_PER_BIT cycles) -> IDLE.
- Latency: tx falls in the first cycle after the accept edge.
- Frame length: (DATA_BITS+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT if parity is enabled.
- done: high for exactly one cycle, the first IDLE cycle after STOP. tx_ready is also 1 in that cycle.
- Back-to-back frames: with tx_valid held, the next word is accepted in the done cycle. Consecutive start-bit falling edges are frame_length+1 cycles apart.
- busy = (state != IDLE).
- Baud counter:
  - width $clog2(CLKS_PER_BIT).
  - counts 0..CLKS_PER_BIT-1; the terminal count advances the bit.
  - clears on every state change.
  - no wrap-around glitch is permitted: each bit lasts exactly CLKS_PER_BIT cycles.
- Bit counter: width $clog2(DATA_BITS+1); leaves DATA after index DATA_BITS-1.
- Reset mid-frame: the frame is abandoned. The cycle after the rst edge shows tx=1 and tx_ready=1, with no done pulse.
- tx_data changes after accept have no effect on the frame in flight.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the latched word, computed at accept) for CLKS_PER_BIT cycles.
- Undefined:
  - no PARITY state.
  - DATA goes directly to STOP.
  - the parity register is not synthesized.

Decomposition:
- Package uart_pkg holds:
  - state typedef (IDLE, START, DATA, PARITY, STOP).
  - constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
  - shared by the future RX block.
- One sub-module, uart_baud_tick:
  - parameter CLKS_PER_BIT; inputs clk, rst, clear; output tick.
  - tick pulses on terminal count.
  - reusable by the receiver.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8):
- Reset: rst high 3 cycles with tx_valid=1 -> tx=1, tx_ready=1, busy=0, done=0 throughout; nothing is accepted until rst is low.
- Single frame 0x55: accept at edge E0 -> tx=0 in cycles 1-4; then bits 1,0,1,0,1,0,1,0 for 4 cycles each in cycles 5-36; tx=1 in cycles 37-40; done=1 only in cycle 41; busy high in cycles 1-40.
- Back-to-back 0xA5 then 0x0F, tx_valid held -> second word accepted in cycle 41; second start bit in cycle 42; the bit stream matches both words LSB-first.
- Busy rejection: tx_valid=1 with tx_data=0xFF during cycle 10 of a 0x3C frame -> tx_ready=0, the 0x3C stream is unaltered, and 0xFF is sent only after done.
- Reset mid-frame: rst asserted during data bit 3 of 0xC3 -> the next cycle shows tx=1, tx_ready=1, busy=0, with no done pulse; a subsequent 0x81 frame transmits correctly.
- UART_TX_PARITY_EN defined:
  - 0x07 -> parity bit 1 in cycles 37-40, stop bit in cycles 41-44, done in cycle 45.
  - 0x03 -> parity bit 0.
